// File: rtl/apb_ram_pkg.sv
// apb_ram_pkg: shared types and elaboration helpers for the parametrised APB RAM
// Provides the FSM state enum, byte-lane / log2 helpers and parameter legality predicates.
package apb_ram_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    function automatic int lane_count(input int dw);
        return dw / 8;
    endfunction

    function automatic int log2_ceil(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit data_width_ok(input int dw);
        return dw == 8 || dw == 16 || dw == 32 || dw == 64;
    endfunction

    function automatic bit wait_states_ok(input int ws);
        return ws >= 0 && ws <= 15;
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// apb_ram_mem: DEPTH x DATA_WIDTH word array with per-byte write enable, no reset
// Ports: clk; we/waddr/wstrb/wdata synchronous byte-masked write; raddr/rdata combinational read.
module apb_ram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_WIDTH-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_ram_param.sv
// apb_ram_param: parametrised APB4 slave RAM with byte strobes, wait states and error reporting
// Ports: pclk/preset (async, active-high); APB request psel/penable/pwrite/paddr/pwdata/pstrb;
// response prdata/pready/pslverr, all registered and cleared outside the completion cycle.
module apb_ram_param
    import apb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int         NB = lane_count(DATA_WIDTH);
    localparam int         LB = log2_ceil(NB);
    localparam int         IW = log2_ceil(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $error("apb_ram_param: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
        $error("apb_ram_param: WAIT_STATES must be 0..15");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("apb_ram_param: DEPTH must be at least 2");
    end

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   strb_q, strb_d;
    logic            err_q, err_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IW-1:0]         in_idx, rd_idx;
    logic                  in_err, setup, commit, start, done, acc_write, acc_err;
    logic [DATA_WIDTH-1:0] mem_rdata, rd_word;

    assign word_addr = paddr >> LB;
    assign in_idx    = IW'(word_addr);
    assign in_err    = ((paddr & ADDR_WIDTH'((1 << LB) - 1)) != '0) ||
                       (word_addr >= ADDR_WIDTH'(DEPTH));
    assign setup     = psel && !penable;
    assign commit    = state_q == ACCESS && pready_q && write_q && !err_q;
    // A wait-state completion reads the latched index; a setup edge reads the live address.
    assign rd_idx    = (state_q == ACCESS && !pready_q) ? idx_q : in_idx;

    // A back-to-back read set up on a write's commit edge must see the bytes being written.
    always_comb begin
        rd_word = mem_rdata;
        for (int i = 0; i < NB; i++) begin
            if (commit && idx_q == rd_idx && strb_q[i]) rd_word[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        start     = 1'b0;
        done      = 1'b0;
        if (state_q == IDLE) begin
            start = setup;
        end else if (pready_q) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            start     = setup;
        end else if (psel && penable) begin
            cnt_d = cnt_q - 4'd1;
            done  = cnt_q == 4'd1;
        end else begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
        end
        if (start) begin
            state_d = ACCESS;
            cnt_d   = WS;
            idx_d   = in_idx;
            write_d = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
            err_d   = in_err;
            done    = WS == 4'd0;
        end
        acc_write = start ? pwrite : write_q;
        acc_err   = start ? in_err : err_q;
        if (done) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = (!acc_write && !acc_err) ? rd_word : '0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    apb_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IW)
    ) u_mem (
        .clk   (pclk),
        .we    (commit),
        .waddr (idx_q),
        .wstrb (strb_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_param.sv
// tb_apb_ram_param: directed bench for apb_ram_param with WAIT_STATES of 0, 2 and 3
module tb_apb_ram_param;

    logic        clk = 1'b0;
    logic        preset  [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_ram_param #(.WAIT_STATES(0)) u0 (
        .pclk(clk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]));

    apb_ram_param #(.WAIT_STATES(2)) u2 (
        .pclk(clk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]));

    apb_ram_param #(.WAIT_STATES(3)) u3 (
        .pclk(clk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is just after a rising edge; returns just after the edge where pready is seen high.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int cyc);
        int n;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = a; pwdata[k] = d; pstrb[k] = s;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        n = 1;
        while (!pready[k] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        rd  = prdata[k];
        err = pslverr[k];
        cyc = pready[k] ? n + 1 : -1;
    endtask

    task automatic idle(input int k);
        psel[k] = 1'b0; penable[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          cyc;
        logic        seen;

        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h80, 32'h00000055, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h80, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[10] = '{1'b0, 32'h06, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h7C, 32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h7C, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[13] = '{1'b1, 32'h12, 32'h0000AAAA, 4'hF, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[15] = '{1'b1, 32'h7E, 32'h0BAD0BAD, 4'hF, 32'h0,        1'b1};

        for (int k = 0; k < 3; k++) begin
            preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d pready", k), 32'(pready[k]), 32'h0);
            chk($sformatf("reset%0d pslverr", k), 32'(pslverr[k]), 32'h0);
            chk($sformatf("reset%0d prdata", k), prdata[k], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) preset[k] = 1'b0;

        // WAIT_STATES=0 vectors, each followed by an idle cycle
        for (int i = 0; i < 16; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err, cyc);
            chk($sformatf("vec%0d cycles", i), 32'(cyc), 32'd2);
            chk($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            idle(0);
            chk($sformatf("vec%0d idle pready", i), 32'(pready[0]), 32'h0);
            chk($sformatf("vec%0d idle prdata", i), prdata[0], 32'h0);
        end

        // Back-to-back write then read of the same word with no wait states
        xfer(0, 1'b1, 32'h20, 32'h600DF00D, 4'hF, rd, err, cyc);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, cyc);
        chk("b2b0 cycles", 32'(cyc), 32'd2);
        chk("b2b0 prdata", rd, 32'h600DF00D);
        idle(0);

        // WAIT_STATES=2: latency and back-to-back read then write
        xfer(1, 1'b1, 32'h8, 32'hA5A55A5A, 4'hF, rd, err, cyc);
        chk("ws2 write cycles", 32'(cyc), 32'd4);
        idle(1);
        xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        chk("ws2 read cycles", 32'(cyc), 32'd4);
        chk("ws2 read prdata", rd, 32'hA5A55A5A);
        xfer(1, 1'b1, 32'hC, 32'h0F0F0F0F, 4'hF, rd, err, cyc);
        chk("ws2 b2b write cycles", 32'(cyc), 32'd4);
        idle(1);
        xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, err, cyc);
        chk("ws2 b2b readback", rd, 32'h0F0F0F0F);
        idle(1);

        // Abort during the first wait cycle of a write
        xfer(1, 1'b1, 32'h4, 32'h01020304, 4'hF, rd, err, cyc);
        idle(1);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h4; pwdata[1] = 32'hCAFE0000; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | pready[1];
        end
        chk("abort pready pulse", 32'(seen), 32'h0);
        xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
        chk("abort next cycles", 32'(cyc), 32'd4);
        chk("abort mem unchanged", rd, 32'h01020304);
        idle(1);

        // WAIT_STATES=3: asynchronous reset while the completion cycle is pending
        xfer(2, 1'b1, 32'h8, 32'h11111111, 4'hF, rd, err, cyc);
        chk("ws3 write cycles", 32'(cyc), 32'd5);
        idle(2);
        xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        chk("ws3 read prdata", rd, 32'h11111111);
        #2 preset[2] = 1'b1;
        #1;
        chk("rst read prdata", prdata[2], 32'h0);
        chk("rst read pready", 32'(pready[2]), 32'h0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        preset[2] = 1'b0;
        xfer(2, 1'b1, 32'h8, 32'h22222222, 4'hF, rd, err, cyc);
        chk("ws3 write2 pready", 32'(cyc), 32'd5);
        #2 preset[2] = 1'b1;
        #1;
        chk("rst write pready", 32'(pready[2]), 32'h0);
        chk("rst write pslverr", 32'(pslverr[2]), 32'h0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        preset[2] = 1'b0;
        xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
        chk("rst write not committed", rd, 32'h11111111);
        chk("rst post cycles", 32'(cyc), 32'd5);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
